// File: rtl/shift_rows_if.sv
// Stream interface for shift_rows_pipe: an input beat channel, an output beat channel and the block counter.
// master = producer/consumer side (testbench or round logic), slave = the pipeline.
interface shift_rows_if #(
  parameter int NB    = 4,
  parameter int CNT_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic              in_inv;
  logic [32*NB-1:0]  state_in;
  logic              out_valid;
  logic              out_ready;
  logic [32*NB-1:0]  state_out;
  logic              out_inv;
  logic [CNT_W-1:0]  blk_cnt;

  modport master (
    output in_valid, in_inv, state_in, out_ready,
    input  in_ready, out_valid, state_out, out_inv, blk_cnt
  );

  modport slave (
    input  in_valid, in_inv, state_in, out_ready,
    output in_ready, out_valid, state_out, out_inv, blk_cnt
  );
endinterface

// File: rtl/shift_rows_pipe.sv
// Pipelined Rijndael ShiftRows/InvShiftRows stage (Nb = 4/6/8, 1..4 elastic register stages).
// Define SHIFT_ROWS_INV_EN to enable the per-beat inverse mode selected by in_inv.
module shift_rows_pipe #(
  parameter int NB     = 4,
  parameter int STAGES = 1,
  parameter int CNT_W  = 16
) (
  input logic         clk,
  input logic         rst,
  shift_rows_if.slave bus
);
  localparam int W = 32 * NB;
  typedef logic [W-1:0] state_t;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("shift_rows_pipe: STAGES must be 1..4");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("shift_rows_pipe: CNT_W must be at least 1");
  end

  // Row rotation amounts; the 256-bit block uses the wider 3/4 offsets on rows 2/3.
  function automatic int row_off(input int r);
    case (r)
      0:       return 0;
      1:       return 1;
      2:       return (NB == 8) ? 3 : 2;
      default: return (NB == 8) ? 4 : 3;
    endcase
  endfunction

  // Byte (r,c) lives at k = 4c+r, counted from the MSB end of the vector.
  function automatic state_t shift_fwd(input state_t s);
    state_t o;
    o = '0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[W-1-8*(4*c+r) -: 8] = s[W-1-8*(4*((c + row_off(r)) % NB)+r) -: 8];
      end
    end
    return o;
  endfunction

`ifdef SHIFT_ROWS_INV_EN
  function automatic state_t shift_inv(input state_t s);
    state_t o;
    o = '0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[W-1-8*(4*c+r) -: 8] = s[W-1-8*(4*((c + NB - row_off(r)) % NB)+r) -: 8];
      end
    end
    return o;
  endfunction
`endif

  // Handshake: a beat moves across a boundary on a rising edge where valid && ready are both 1;
  // valid never depends on ready, and a held beat keeps data/inv stable until it moves.
  logic             stg_valid [STAGES];
  state_t           stg_data  [STAGES];
  logic             stg_load  [STAGES];
  logic             up_valid  [STAGES];
  state_t           up_data   [STAGES];
  logic [CNT_W-1:0] cnt;
  state_t           perm;

`ifdef SHIFT_ROWS_INV_EN
  logic stg_inv [STAGES];
  logic up_inv  [STAGES];

  assign perm = bus.in_inv ? shift_inv(bus.state_in) : shift_fwd(bus.state_in);
`else
  logic unused_in_inv;

  assign unused_in_inv = bus.in_inv;
  assign perm          = shift_fwd(bus.state_in);
`endif

  // A stage can load if it is empty or its content leaves this cycle; this ripples back from out_ready.
  always_comb begin : load_chain
    logic take;
    take = bus.out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      take        = !stg_valid[i] || take;
      stg_load[i] = take;
    end
  end

  always_comb begin : upstream_sel
    for (int i = 0; i < STAGES; i++) begin
      if (i == 0) begin
        up_valid[i] = bus.in_valid;
        up_data[i]  = perm;
      end else begin
        up_valid[i] = stg_valid[i-1];
        up_data[i]  = stg_data[i-1];
      end
    end
  end

`ifdef SHIFT_ROWS_INV_EN
  always_comb begin : upstream_inv
    for (int i = 0; i < STAGES; i++) begin
      up_inv[i] = (i == 0) ? bus.in_inv : stg_inv[i-1];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stg_valid[i] <= 1'b0;
        stg_data[i]  <= '0;
`ifdef SHIFT_ROWS_INV_EN
        stg_inv[i]   <= 1'b0;
`endif
      end
      cnt <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (stg_load[i]) begin
          stg_valid[i] <= up_valid[i];
          // Data only moves with a real beat so an idle stage keeps its last contents.
          if (up_valid[i]) begin
            stg_data[i] <= up_data[i];
`ifdef SHIFT_ROWS_INV_EN
            stg_inv[i]  <= up_inv[i];
`endif
          end
        end
      end
      if (stg_valid[STAGES-1] && bus.out_ready) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.in_ready  = stg_load[0] && !rst;
  assign bus.out_valid = stg_valid[STAGES-1];
  assign bus.state_out = stg_data[STAGES-1];
  assign bus.blk_cnt   = cnt;
`ifdef SHIFT_ROWS_INV_EN
  assign bus.out_inv   = stg_inv[STAGES-1];
`else
  assign bus.out_inv   = 1'b0;
`endif

endmodule
